// File: rtl/vx_mem_responder_pkg.sv
// rtl/vx_mem_responder_pkg.sv - shared types, defaults and helpers for the memory responder
package vx_mem_responder_pkg;

    localparam int MEM_DATA_WIDTH     = 512;
    localparam int MEM_TAG_WIDTH      = 8;
    localparam int MEM_RSP_QUEUE_SIZE = 8;

    // One response as it travels through the delay pipeline and the response queue
    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] data;
        logic [MEM_TAG_WIDTH-1:0]  tag;
    } mem_rsp_entry_t;

    // Width of the outstanding-credit counter: must be able to hold the value qsize itself
    function automatic int mem_responder_cnt_w(input int qsize);
        return $clog2(qsize) + 1;
    endfunction

endpackage

// File: rtl/vx_mem_responder_delay.sv
// rtl/vx_mem_responder_delay.sv - fixed-length valid/data shift pipeline with synchronous active-low clear
module vx_mem_responder_delay #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign m_tvalid = s_tvalid;
            assign m_tdata  = s_tdata;
        end else begin : g_pipe
            logic [STAGES-1:0] vld;
            logic [WIDTH-1:0]  dat [STAGES];

            // Shift every stage one step per cycle; clearing drops anything in flight
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    vld <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        dat[i] <= '0;
                    end
                end else begin
                    vld[0] <= s_tvalid;
                    dat[0] <= s_tdata;
                    for (int i = 1; i < STAGES; i++) begin
                        vld[i] <= vld[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            assign m_tvalid = vld[STAGES-1];
            assign m_tdata  = dat[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/vx_mem_responder_fifo.sv
// rtl/vx_mem_responder_fifo.sv - power-of-two FIFO queue primitive with zeroed idle output
module vx_mem_responder_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             s_tready,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = s_tvalid && !full;
    assign pop      = m_tready && !empty;
    assign s_tready = !full;
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : ram[rd_ptr[AW-1:0]];

    // Storage is not reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            ram[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Upstream credit accounting must make a push into a full queue impossible
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(s_tvalid && full));
        end
    end

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - line memory responder with fixed read latency; optional VX_MEM_RESPONDER_WRACK_EN
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
    parameter int BYTEEN_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = MEM_TAG_WIDTH,
    parameter int DEPTH_LOG2     = 12,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = MEM_RSP_QUEUE_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy
);

    localparam int CNT_W   = mem_responder_cnt_w(RSP_QUEUE_SIZE);
    localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];
    logic [CNT_W-1:0]      pending;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  credit_fire;
    logic [DATA_WIDTH-1:0] rsp_line;
    logic                  pipe_valid;
    logic [ENTRY_W-1:0]    pipe_data;
    logic [ENTRY_W-1:0]    head_data;
    logic                  fifo_ready_unused;

    // Upper address bits alias onto the implemented lines
    assign idx = mem_req_addr[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    assign mem_req_ready = reset && (pending < CNT_W'(RSP_QUEUE_SIZE));
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    assign busy          = (pending != '0);

`ifdef VX_MEM_RESPONDER_WRACK_EN
    assign credit_fire = req_fire;
    assign rsp_line    = mem_req_rw ? '0 : mem[idx];
`else
    assign credit_fire = req_fire && !mem_req_rw;
    assign rsp_line    = mem[idx];
`endif

    // Byte-masked line writes; contents survive reset
    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw) begin
            for (int i = 0; i < BYTEEN_WIDTH; i++) begin
                if (mem_req_byteen[i]) begin
                    mem[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
                end
            end
        end
    end

    // Outstanding responses: one credit per response-producing request, returned on pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else if (credit_fire && !rsp_fire) begin
            pending <= pending + 1'b1;
        end else if (!credit_fire && rsp_fire) begin
            pending <= pending - 1'b1;
        end
    end

    vx_mem_responder_delay #(
        .STAGES (LATENCY - 1),
        .WIDTH  (ENTRY_W)
    ) u_delay (
        .clk      (clk),
        .resetn   (reset),
        .s_tvalid (credit_fire),
        .s_tdata  ({rsp_line, mem_req_tag}),
        .m_tvalid (pipe_valid),
        .m_tdata  (pipe_data)
    );

    vx_mem_responder_fifo #(
        .DEPTH (RSP_QUEUE_SIZE),
        .WIDTH (ENTRY_W)
    ) u_rsp_queue (
        .clk      (clk),
        .resetn   (reset),
        .s_tvalid (pipe_valid),
        .s_tdata  (pipe_data),
        .s_tready (fifo_ready_unused),
        .m_tvalid (mem_rsp_valid),
        .m_tdata  (head_data),
        .m_tready (mem_rsp_ready)
    );

    assign {mem_rsp_data, mem_rsp_tag} = head_data;

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - self-checking bench for vx_mem_responder against a line-array/queue model
module tb_vx_mem_responder;

    localparam int DW  = 512;
    localparam int BW  = 64;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int DL  = 12;
    localparam int LAT = 4;
    localparam int QS  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_rw;
    logic [BW-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic [DW-1:0] model_mem [int];
    exp_t          exp_q [$];

    always #5 clk = ~clk;

    vx_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy)
    );

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Offer one request, wait up to max_wait extra cycles; on accept update the model
    task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BW-1:0] be, input logic [TW-1:0] tag, input int max_wait,
                        output bit ok);
        int idx;
        ok = 0;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_data   = data;
        mem_req_byteen = be;
        mem_req_tag    = tag;
        for (int i = 0; i <= max_wait; i++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        mem_req_valid = 1'b0;
        if (ok) begin
            idx = int'(addr % (1 << DL));
            if (rw) begin
                if (!model_mem.exists(idx)) model_mem[idx] = '0;
                for (int b = 0; b < BW; b++)
                    if (be[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            end else begin
                exp_q.push_back('{model_mem[idx], tag});
            end
        end
    endtask

    // Accept one response within max_wait cycles
    task automatic recv(input int max_wait, output bit ok, output logic [DW-1:0] d,
                        output logic [TW-1:0] t);
        ok = 0;
        d  = '0;
        t  = '0;
        mem_rsp_ready = 1'b1;
        for (int i = 0; i <= max_wait; i++) begin
            @(negedge clk);
            if (mem_rsp_valid) begin
                d  = mem_rsp_data;
                t  = mem_rsp_tag;
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        mem_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_req_tag = '0;
        mem_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", mem_req_ready); end
        checks++; if (mem_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", mem_rsp_valid); end
        checks++; if (mem_rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", mem_rsp_data); end
        checks++; if (mem_rsp_tag !== '0) begin failures++; $display("FAIL reset_rsp_tag got=%h exp=0", mem_rsp_tag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", mem_req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        bit ok;
        logic [DW-1:0] a5;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        a5 = {64{8'hA5}};
        send(1'b1, 26'h10, a5, '1, 8'h0, 4, ok);
        send(1'b0, 26'h10, '0, '0, 8'h3, 4, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", ok); end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++;
            if (mem_rsp_valid !== (k == LAT)) begin
                failures++; $display("FAIL single_latency cycle=%0d got=%b exp=%b", k, mem_rsp_valid, (k == LAT));
            end
            if (k < LAT) begin @(posedge clk); #1; end
        end
        checks++; if (mem_rsp_data !== a5) begin failures++; $display("FAIL single_data got=%h exp=%h", mem_rsp_data, a5); end
        checks++; if (mem_rsp_tag !== 8'h3) begin failures++; $display("FAIL single_tag got=%h exp=03", mem_rsp_tag); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        recv(4, ok, d, t);
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_byteen_merge();
        bit ok;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        send(1'b1, 26'h5, '0, '1, 8'h0, 4, ok);
        send(1'b1, 26'h5, '1, 64'h1, 8'h0, 4, ok);
        send(1'b0, 26'h5, '0, '0, 8'h7, 4, ok);
        recv(20, ok, d, t);
        void'(exp_q.pop_front());
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL merge_timeout got=%b exp=1", ok); end
        checks++; if (d !== 512'hFF) begin failures++; $display("FAIL merge_data got=%h exp=ff", d); end
        checks++; if (t !== 8'h7) begin failures++; $display("FAIL merge_tag got=%h exp=07", t); end
    endtask

    task automatic test_alias();
        bit ok;
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        w = rand_line();
        send(1'b1, 26'h1005, w, '1, 8'h0, 4, ok);
        send(1'b0, 26'h0005, '0, '0, 8'h21, 4, ok);
        recv(20, ok, d, t);
        void'(exp_q.pop_front());
        checks++; if (d !== w || t !== 8'h21) begin failures++; $display("FAIL alias got=%h/%h exp=%h/21", d, t, w); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int accepted;
        for (int i = 0; i < 10; i++) send(1'b1, AW'(32'h20 + i), rand_line(), '1, 8'h0, 4, ok);
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, AW'(32'h20 + i), '0, '0, TW'(i), 3, ok);
            if (ok) accepted++;
        end
        @(negedge clk);
        checks++; if (accepted != QS) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", accepted, QS); end
        checks++; if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", mem_req_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        fork
            begin
                bit ok8;
                bit ok9;
                send(1'b0, 26'h28, '0, '0, 8'd8, 40, ok8);
                send(1'b0, 26'h29, '0, '0, 8'd9, 40, ok9);
                checks++; if (!(ok8 && ok9)) begin failures++; $display("FAIL bp_late_accept got=%b%b exp=11", ok8, ok9); end
            end
            begin
                bit rok;
                logic [DW-1:0] d;
                logic [TW-1:0] t;
                exp_t e;
                for (int j = 0; j < 10; j++) begin
                    recv(40, rok, d, t);
                    e = exp_q.size() > 0 ? exp_q.pop_front() : '{'0, '0};
                    checks++;
                    if (!rok || t !== TW'(j) || d !== e.data) begin
                        failures++; $display("FAIL bp_order idx=%0d got_tag=%h exp_tag=%h data_ok=%b", j, t, TW'(j), d === e.data);
                    end
                end
            end
        join
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drained_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        exp_t e;
        for (int i = 0; i < 8; i++) send(1'b1, AW'(32'h40 + i), rand_line(), '1, 8'h0, 4, ok);
        for (int i = 0; i < 7; i++) send(1'b0, AW'(32'h40 + i), '0, '0, TW'(32'h50 + i), 2, ok);
        repeat (LAT) @(posedge clk);
        #1;
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h47; mem_req_tag = 8'h57;
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (!(mem_req_ready && mem_rsp_valid)) begin failures++; $display("FAIL sim_both_fire got=%b%b exp=11", mem_req_ready, mem_rsp_valid); end
        e = exp_q.pop_front();
        checks++; if (mem_rsp_tag !== e.tag || mem_rsp_data !== e.data) begin failures++; $display("FAIL sim_head got_tag=%h exp_tag=%h", mem_rsp_tag, e.tag); end
        @(posedge clk); #1;
        exp_q.push_back('{model_mem[12'h47], 8'h57});
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL sim_count_kept got=%b exp=1", mem_req_ready); end
        @(posedge clk); #1;
        send(1'b0, 26'h40, '0, '0, 8'h58, 0, ok);
        @(negedge clk);
        checks++; if (!ok || mem_req_ready !== 1'b0) begin failures++; $display("FAIL sim_full got_ok=%b got_ready=%b exp=1/0", ok, mem_req_ready); end
        @(posedge clk); #1;
        for (int j = 0; j < QS; j++) begin
            recv(20, ok, d, t);
            e = exp_q.size() > 0 ? exp_q.pop_front() : '{'0, '0};
            checks++;
            if (!ok || t !== e.tag || d !== e.data) begin failures++; $display("FAIL sim_drain idx=%0d got_tag=%h exp_tag=%h", j, t, e.tag); end
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                bit ok;
                int stalls;
                stalls = 0;
                for (int i = 0; i < 12; i++) begin
                    send(1'b0, AW'(32'h40 + (i % 8)), '0, '0, TW'(32'h80 + i), 0, ok);
                    if (!ok) stalls++;
                end
                checks++; if (stalls != 0) begin failures++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
            end
            begin
                bit rok;
                logic [DW-1:0] d;
                logic [TW-1:0] t;
                exp_t e;
                for (int j = 0; j < 12; j++) begin
                    recv(20, rok, d, t);
                    e = exp_q.size() > 0 ? exp_q.pop_front() : '{'0, '0};
                    checks++;
                    if (!rok || t !== e.tag || d !== e.data) begin failures++; $display("FAIL b2b_rsp idx=%0d got_tag=%h exp_tag=%h", j, t, e.tag); end
                end
            end
        join
    endtask

    task automatic test_random();
        bit a_done;
        bit ok;
        a_done = 0;
        for (int i = 0; i < 16; i++) send(1'b1, AW'(32'h60 + i), rand_line(), '1, 8'h0, 4, ok);
        fork
            begin
                bit sok;
                int lost;
                logic [AW-1:0] a;
                lost = 0;
                for (int i = 0; i < 150; i++) begin
                    a = AW'($urandom);
                    a[DL-1:0] = 12'h060 + 12'($urandom_range(0, 15));
                    send(1'($urandom_range(0, 1)), a, rand_line(), {$urandom, $urandom}, TW'(i), 60, sok);
                    if (!sok) lost++;
                end
                checks++; if (lost != 0) begin failures++; $display("FAIL rand_accept lost=%0d exp=0", lost); end
                a_done = 1;
            end
            begin
                exp_t e;
                int cyc;
                cyc = 0;
                while (!(a_done && exp_q.size() == 0) && cyc < 5000) begin
                    mem_rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (mem_rsp_valid && mem_rsp_ready) begin
                        e = exp_q.size() > 0 ? exp_q.pop_front() : '{'0, '0};
                        checks++;
                        if (mem_rsp_tag !== e.tag || mem_rsp_data !== e.data) begin
                            failures++; $display("FAIL rand_rsp got_tag=%h exp_tag=%h data_ok=%b", mem_rsp_tag, e.tag, mem_rsp_data === e.data);
                        end
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                mem_rsp_ready = 1'b0;
                checks++; if (cyc >= 5000) begin failures++; $display("FAIL rand_timeout pending=%0d exp=0", exp_q.size()); end
            end
        join
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int seen;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        for (int i = 0; i < 3; i++) send(1'b0, AW'(32'h60 + i), '0, '0, TW'(32'hC0 + i), 4, ok);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        seen = 0;
        mem_rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_rsp_valid) seen++;
            @(posedge clk); #1;
        end
        mem_rsp_ready = 1'b0;
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_reset_dropped got=%0d exp=0", seen); end
        send(1'b0, 26'h62, '0, '0, 8'hD2, 4, ok);
        recv(20, ok, d, t);
        checks++;
        if (!ok || t !== 8'hD2 || d !== model_mem[12'h62]) begin failures++; $display("FAIL mid_reset_retained got_tag=%h exp_tag=d2 data_ok=%b", t, d === model_mem[12'h62]); end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byteen_merge();
        test_alias();
        test_backpressure();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete checks=%0d", checks);
        $fatal(1);
    end

endmodule
